// File: rtl/pic_ctl_if.sv
// CPU port bus as seen by the interrupt controller.
//   port_clk : one-cycle access strobe (CPU -> controller)
//   port     : 16-bit I/O port address
//   port_o   : write data from the CPU
//   port_w   : 1 = write, 0 = read
//   port_i   : registered read data back to the CPU
interface pic_ctl_if;
    logic        port_clk;
    logic [15:0] port;
    logic [7:0]  port_o;
    logic        port_w;
    logic [7:0]  port_i;

    modport master (output port_clk, port, port_o, port_w, input port_i);
    modport slave  (input port_clk, port, port_o, port_w, output port_i);
endinterface

// File: rtl/pic_ctl.sv
// Parametrised edge-triggered interrupt controller with fixed priority
// (line 0 highest), nested delivery and specific/non-specific EOI.
// Ports:
//   clock, resetn : host clock, synchronous active-low reset
//   bus           : CPU port bus (slave side), six ports from BASE_PORT
//   irq_in        : NIRQ request lines, rising-edge sensitive
//   intr          : toggles once per delivered interrupt
//   irq           : vector of the last delivered interrupt
//   intr_latch    : CPU copy of intr; equal to intr once accepted
module pic_ctl #(
    parameter int unsigned NIRQ       = 8,
    parameter logic [15:0] BASE_PORT  = 16'h0020,
    parameter logic [7:0]  VECT_RESET = 8'h08
) (
    input  logic            clock,
    input  logic            resetn,
    pic_ctl_if.slave        bus,
    input  logic [NIRQ-1:0] irq_in,
    output logic            intr,
    output logic [7:0]      irq,
    input  logic            intr_latch
);
    // Vector base keeps enough low bits clear to hold the line number
    localparam logic [7:0] VECT_MASK = (NIRQ > 8) ? 8'hF0 : 8'hF8;

    logic [NIRQ-1:0] imr;
    logic [NIRQ-1:0] irr;
    logic [NIRQ-1:0] isr;
    logic [NIRQ-1:0] irq_s;
    logic [NIRQ-1:0] irq_prev;
    logic [7:0]      vect_base;

    logic [15:0]     port_off;
    logic            wr_strobe;
    logic            rd_strobe;
    logic [15:0]     imr_w;
    logic [15:0]     irr_w;
    logic [NIRQ-1:0] imr_nxt;
    logic [NIRQ-1:0] rise_c;
    logic [NIRQ-1:0] eoi_clr;
    logic [NIRQ-1:0] dlv_set;
    logic            dlv_go;
    logic            dlv_blocked;
    logic            eoi_found;
    logic [7:0]      dlv_vect;
    logic [7:0]      rd_data;

    // Port decode
    always_comb begin
        port_off  = bus.port - BASE_PORT;
        wr_strobe = bus.port_clk & bus.port_w;
        rd_strobe = bus.port_clk & ~bus.port_w;
        imr_w     = 16'(imr);
        irr_w     = 16'(irr);
        rise_c    = irq_s & ~irq_prev;
    end

    // Mask register after this cycle's write; the new mask gates this cycle's edges
    always_comb begin
        imr_nxt = imr;
        for (int unsigned i = 0; i < NIRQ; i++) begin
            if (wr_strobe && port_off == 16'd1 && i < 8)
                imr_nxt[i] = bus.port_o[3'(i)];
            if (wr_strobe && port_off == 16'd2 && i >= 8)
                imr_nxt[i] = bus.port_o[3'(i - 8)];
        end
    end

    // EOI decode: 001xxxxx clears lowest ISR bit, 011nnnnn clears ISR[n]
    always_comb begin
        eoi_clr   = '0;
        eoi_found = 1'b0;
        if (wr_strobe && port_off == 16'd0) begin
            if (bus.port_o[7:5] == 3'b001) begin
                for (int unsigned i = 0; i < NIRQ; i++) begin
                    if (!eoi_found && isr[i]) begin
                        eoi_clr[i] = 1'b1;
                        eoi_found  = 1'b1;
                    end
                end
            end else if (bus.port_o[7:5] == 3'b011) begin
                for (int unsigned i = 0; i < NIRQ; i++) begin
                    if (32'(bus.port_o[4:0]) == i)
                        eoi_clr[i] = 1'b1;
                end
            end
        end
    end

    // Priority scan on pre-EOI ISR: stop at the first in-service line
    always_comb begin
        dlv_set     = '0;
        dlv_go      = 1'b0;
        dlv_blocked = 1'b0;
        dlv_vect    = vect_base;
        if (intr == intr_latch) begin
            for (int unsigned i = 0; i < NIRQ; i++) begin
                if (!dlv_blocked && !dlv_go) begin
                    if (isr[i]) begin
                        dlv_blocked = 1'b1;
                    end else if (irr[i]) begin
                        dlv_go     = 1'b1;
                        dlv_set[i] = 1'b1;
                        dlv_vect   = vect_base + 8'(i);
                    end
                end
            end
        end
    end

    // Read mux; unimplemented bits come back as zero through the casts
    always_comb begin
        case (port_off)
            16'd0:   rd_data = 8'(isr);
            16'd1:   rd_data = imr_w[7:0];
            16'd2:   rd_data = imr_w[15:8];
            16'd3:   rd_data = vect_base;
            16'd4:   rd_data = irr_w[7:0];
            16'd5:   rd_data = irr_w[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    // State update; a new edge wins over delivery clearing the same IRR bit
    always_ff @(posedge clock) begin
        if (!resetn) begin
            imr        <= '0;
            irr        <= '0;
            isr        <= '0;
            irq_s      <= '0;
            irq_prev   <= '0;
            vect_base  <= VECT_RESET;
            intr       <= 1'b0;
            irq        <= 8'h00;
            bus.port_i <= 8'h00;
        end else begin
            irq_s    <= irq_in;
            irq_prev <= irq_s;
            imr      <= imr_nxt;
            irr      <= (irr & ~dlv_set & ~imr_nxt) | (rise_c & ~imr_nxt);
            isr      <= (isr & ~eoi_clr) | dlv_set;
            if (wr_strobe && port_off == 16'd3)
                vect_base <= bus.port_o & VECT_MASK;
            if (dlv_go) begin
                intr <= ~intr;
                irq  <= dlv_vect;
            end
            if (rd_strobe && port_off < 16'd6)
                bus.port_i <= rd_data;
        end
    end
endmodule

// File: tb/tb_pic_ctl.sv
// Scoreboard bench for pic_ctl: an 8-line and a 16-line instance share all
// stimulus; a per-instance reference model predicts deliveries and read data.
`timescale 1ns/1ps
module tb_pic_ctl;
    localparam logic [15:0] BASE = 16'h0020;

    typedef struct {
        int         cyc;
        logic [7:0] v;
    } exp_t;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetn = 1'b0;
    logic        b_pc = 1'b0;
    logic        b_w = 1'b0;
    logic [15:0] b_a = 16'h0;
    logic [7:0]  b_d = 8'h0;
    logic [15:0] b_irq = 16'h0;
    logic        b_latch [2];

    logic        intr8, intr16;
    logic [7:0]  irq8, irq16;

    pic_ctl_if bus8 ();
    pic_ctl_if bus16 ();

    assign bus8.port_clk  = b_pc;
    assign bus8.port      = b_a;
    assign bus8.port_o    = b_d;
    assign bus8.port_w    = b_w;
    assign bus16.port_clk = b_pc;
    assign bus16.port     = b_a;
    assign bus16.port_o   = b_d;
    assign bus16.port_w   = b_w;

    pic_ctl #(.NIRQ(8), .BASE_PORT(16'h0020), .VECT_RESET(8'h08)) u8 (
        .clock(clock), .resetn(resetn), .bus(bus8), .irq_in(b_irq[7:0]),
        .intr(intr8), .irq(irq8), .intr_latch(b_latch[0]));

    pic_ctl #(.NIRQ(16), .BASE_PORT(16'h0020), .VECT_RESET(8'h08)) u16 (
        .clock(clock), .resetn(resetn), .bus(bus16), .irq_in(b_irq),
        .intr(intr16), .irq(irq16), .intr_latch(b_latch[1]));

    // Reference model state, one slot per instance (0: 8 lines, 1: 16 lines)
    logic [15:0] m_imr [2];
    logic [15:0] m_irr [2];
    logic [15:0] m_isr [2];
    logic [15:0] m_s   [2];
    logic [15:0] m_p   [2];
    logic [7:0]  m_vb  [2];
    logic [7:0]  m_pi  [2];
    logic        m_intr[2];
    int          ackdly[2];

    exp_t dq0[$], dq1[$], rq0[$], rq1[$];

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic rst_app = 1'b0;
    bit   hold_ack = 1'b0;
    bit   rand_irq = 1'b0;

    task automatic check(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d cyc%0d: got %02h expected %02h", name, k, cyc, act, exp);
        end
    endtask

    function automatic int lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++)
            if (v[i]) return i;
        return 16;
    endfunction

    // One clock of the specified behaviour, from the inputs applied at this edge
    task automatic model_step(input int k);
        int          n, li, ln;
        logic [15:0] lm, off, imr_n, rise, dlv, eoi;
        logic [7:0]  rdv, vb_old;
        exp_t        e;
        n  = (k == 0) ? 8 : 16;
        lm = (k == 0) ? 16'h00FF : 16'hFFFF;
        if (!resetn) begin
            m_imr[k] = 16'h0; m_irr[k] = 16'h0; m_isr[k] = 16'h0;
            m_s[k] = 16'h0; m_p[k] = 16'h0;
            m_vb[k] = 8'h08; m_pi[k] = 8'h00; m_intr[k] = 1'b0; ackdly[k] = 0;
            return;
        end
        off = b_a - BASE;
        if (b_pc && !b_w) begin
            case (off)
                16'd0:   rdv = m_isr[k][7:0];
                16'd1:   rdv = m_imr[k][7:0];
                16'd2:   rdv = m_imr[k][15:8];
                16'd3:   rdv = m_vb[k];
                16'd4:   rdv = m_irr[k][7:0];
                16'd5:   rdv = m_irr[k][15:8];
                default: rdv = m_pi[k];
            endcase
            m_pi[k] = rdv;
            e.cyc = cyc; e.v = rdv;
            if (k == 0) rq0.push_back(e); else rq1.push_back(e);
        end
        imr_n = m_imr[k];
        if (b_pc && b_w && off == 16'd1) imr_n[7:0] = b_d;
        if (b_pc && b_w && off == 16'd2) imr_n[15:8] = b_d;
        imr_n = imr_n & lm;
        rise  = m_s[k] & ~m_p[k];
        eoi   = 16'h0;
        if (b_pc && b_w && off == 16'd0) begin
            if (b_d[7:5] == 3'b001 && m_isr[k] != 16'h0) eoi[lowest(m_isr[k])] = 1'b1;
            if (b_d[7:5] == 3'b011 && int'(b_d[4:0]) < n) eoi[b_d[3:0]] = 1'b1;
        end
        dlv    = 16'h0;
        vb_old = m_vb[k];
        if (m_intr[k] == b_latch[k]) begin
            li = lowest(m_isr[k]);
            ln = lowest(m_irr[k]);
            if (ln < li) begin
                dlv[ln]   = 1'b1;
                m_intr[k] = ~m_intr[k];
                e.cyc = cyc; e.v = vb_old + 8'(ln);
                if (k == 0) dq0.push_back(e); else dq1.push_back(e);
                ackdly[k] = hold_ack ? 50 : int'($urandom_range(0, 3));
            end
        end
        if (b_pc && b_w && off == 16'd3) m_vb[k] = b_d & ((n > 8) ? 8'hF0 : 8'hF8);
        m_irr[k] = (m_irr[k] & ~dlv & ~imr_n) | (rise & ~imr_n);
        m_isr[k] = (m_isr[k] & ~eoi) | dlv;
        m_imr[k] = imr_n;
        m_p[k]   = m_s[k];
        m_s[k]   = b_irq & lm;
    endtask

    // CPU acknowledge, optional random line activity, then one clock edge
    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            if (resetn && m_intr[k] != b_latch[k]) begin
                if (ackdly[k] == 0) b_latch[k] = m_intr[k];
                else ackdly[k]--;
            end
        end
        if (rand_irq) b_irq = b_irq ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
        @(posedge clock);
        cyc++;
        rst_app = resetn;
        model_step(0);
        model_step(1);
        @(negedge clock);
    endtask

    task automatic drive(input logic pc, input logic [15:0] a, input logic [7:0] d, input logic w);
        b_pc = pc; b_a = a; b_d = d; b_w = w;
    endtask

    task automatic wr(input int off, input logic [7:0] d);
        drive(1'b1, BASE + 16'(off), d, 1'b1);
        tick();
        drive(1'b0, 16'h0, 8'h0, 1'b0);
    endtask

    task automatic rd(input int off);
        drive(1'b1, BASE + 16'(off), 8'h0, 1'b0);
        tick();
        drive(1'b0, 16'h0, 8'h0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input logic [15:0] lines);
        b_irq = b_irq | lines;
        tick();
        b_irq = b_irq & ~lines;
    endtask

    task automatic reset_dut(input int n);
        drive(1'b0, 16'h0, 8'h0, 1'b0);
        resetn = 1'b0;
        b_latch[0] = 1'b0;
        b_latch[1] = 1'b0;
        idle(n);
        resetn = 1'b1;
    endtask

    // Monitor: pops expectations whenever a DUT presents an intr toggle or read data
    logic last_intr [2];
    initial begin
        exp_t       h;
        int         sz;
        logic       ci;
        logic [7:0] cq, cp;
        last_intr[0] = 1'b0;
        last_intr[1] = 1'b0;
        forever begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                ci = (k == 0) ? intr8 : intr16;
                cq = (k == 0) ? irq8 : irq16;
                cp = (k == 0) ? bus8.port_i : bus16.port_i;
                if (!rst_app) begin
                    check("reset_intr", k, 8'(ci), 8'h00);
                    check("reset_irq", k, cq, 8'h00);
                    check("reset_port_i", k, cp, 8'h00);
                    last_intr[k] = ci;
                end else begin
                    sz = (k == 0) ? dq0.size() : dq1.size();
                    if (ci !== last_intr[k]) begin
                        last_intr[k] = ci;
                        n_vec++;
                        if (sz == 0) begin
                            n_err++;
                            $display("FAIL spurious_intr inst%0d cyc%0d: got toggle expected none", k, cyc);
                        end else begin
                            h = (k == 0) ? dq0.pop_front() : dq1.pop_front();
                            if (h.cyc != cyc) begin
                                n_err++;
                                $display("FAIL intr_timing inst%0d: got cyc%0d expected cyc%0d", k, cyc, h.cyc);
                            end
                            check("irq_vector", k, cq, h.v);
                        end
                    end else if (sz != 0) begin
                        h = (k == 0) ? dq0[0] : dq1[0];
                        if (h.cyc <= cyc) begin
                            if (k == 0) void'(dq0.pop_front()); else void'(dq1.pop_front());
                            n_vec++;
                            n_err++;
                            $display("FAIL missing_intr inst%0d cyc%0d: got no toggle expected irq %02h", k, cyc, h.v);
                        end
                    end
                    sz = (k == 0) ? rq0.size() : rq1.size();
                    if (sz != 0) begin
                        h = (k == 0) ? rq0[0] : rq1[0];
                        if (h.cyc <= cyc) begin
                            if (k == 0) void'(rq0.pop_front()); else void'(rq1.pop_front());
                            check("port_read", k, cp, h.v);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        b_latch[0] = 1'b0;
        b_latch[1] = 1'b0;
        reset_dut(3);
        tick();
        for (int o = 0; o < 6; o++) rd(o);

        // Single request on line 3, then ack and non-specific EOI
        pulse(16'h0008); idle(3); rd(0); rd(4);
        wr(0, 8'h20); rd(0);

        // Masked edge is dropped; unmasked edge delivers
        wr(1, 8'h04); pulse(16'h0004); idle(4); rd(4);
        wr(1, 8'h00); pulse(16'h0004); idle(4); wr(0, 8'h20);

        // Simultaneous edges on lines 5 and 1
        pulse(16'h0022); idle(4); wr(0, 8'h20); idle(4); wr(0, 8'h20); idle(2);

        // Nesting: 4 then 0, line 6 waits for both EOIs; specific EOI 0x64
        pulse(16'h0010); idle(4); pulse(16'h0001); idle(4); rd(0);
        pulse(16'h0040); idle(6); wr(0, 8'h64); idle(3); rd(0);
        wr(0, 8'h60); idle(6); rd(0); wr(0, 8'h66); rd(0);

        // Busy hold: no delivery while the CPU has not acknowledged
        hold_ack = 1'b1;
        pulse(16'h0004); tick();
        hold_ack = 1'b0;
        pulse(16'h0002); idle(55); rd(0);
        wr(0, 8'h20); wr(0, 8'h20); idle(2);

        // Vector base masking, line 12, IRR high byte, reset while pending
        wr(3, 8'h77); rd(3);
        pulse(16'h1000); rd(5); idle(3); rd(0); wr(0, 8'h6C); rd(0);
        wr(3, 8'hFF); rd(3); wr(2, 8'hFF); rd(2); wr(2, 8'h00);
        pulse(16'h1020); tick(); reset_dut(2);
        for (int o = 0; o < 6; o++) rd(o);

        // Randomised traffic
        rand_irq = 1'b1;
        for (int it = 0; it < 3000; it++) begin
            r = int'($urandom_range(0, 199));
            hold_ack = ($urandom_range(0, 19) == 0);
            if (r < 80) tick();
            else if (r < 110) wr(int'($urandom_range(1, 3)),
                                 ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
            else if (r < 140) rd(int'($urandom_range(0, 7)));
            else if (r < 170) begin
                case ($urandom_range(0, 2))
                    0: wr(0, 8'h20);
                    1: wr(0, 8'h60 | 8'($urandom_range(0, 15)));
                    default: wr(0, 8'($urandom));
                endcase
            end else if (r < 197) begin
                drive(1'b1, 16'($urandom), 8'($urandom), 1'($urandom));
                tick();
                drive(1'b0, 16'h0, 8'h0, 1'b0);
            end else reset_dut(int'($urandom_range(1, 2)));
        end

        // Drain
        rand_irq = 1'b0;
        hold_ack = 1'b0;
        b_irq = 16'h0;
        for (int i = 0; i < 20; i++) begin
            wr(0, 8'h20);
            idle(2);
        end
        idle(10);
        n_vec++;
        if (dq0.size() + dq1.size() + rq0.size() + rq1.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations expected 0",
                     dq0.size() + dq1.size() + rq0.size() + rq1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
